// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one synchronous song ROM between channel sequencers
// Optional macro ROM_ARB_FIXED_PRIO0_EN: requester 0 always wins when pending.
module rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  output logic [NUM_REQ-1:0]        o_busy,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [ADDR_W-1:0]         o_rom_addr,
  input  logic [DATA_W-1:0]         i_rom_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] inflight;
  logic [ADDR_W-1:0]  addr_q [NUM_REQ];
  logic [IDX_W-1:0]   last;

  logic               grant_valid;
  logic [IDX_W-1:0]   win;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] capture;
  int                 rr_idx;

  // Walk from the farthest candidate back to last+1 so the nearest pending one wins.
  always_comb begin
    grant_valid = 1'b0;
    win         = '0;
    rr_idx      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = (int'(last) + k) % NUM_REQ;
      if (pending[IDX_W'(rr_idx)]) begin
        grant_valid = 1'b1;
        win         = IDX_W'(rr_idx);
      end
    end
`ifdef ROM_ARB_FIXED_PRIO0_EN
    if (pending[0]) begin
      win = '0;
    end
`endif
  end

  assign grant_onehot = grant_valid ? (NUM_REQ'(1) << win) : '0;
  assign capture      = i_req & ~pending;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending  <= '0;
      inflight <= '0;
      last     <= LAST_RST;
      for (int n = 0; n < NUM_REQ; n++) begin
        addr_q[n] <= '0;
      end
    end else begin
      pending  <= (pending | capture) & ~grant_onehot;
      inflight <= grant_onehot;
      for (int n = 0; n < NUM_REQ; n++) begin
        if (capture[n]) begin
          addr_q[n] <= i_addr[n*ADDR_W +: ADDR_W];
        end
      end
`ifdef ROM_ARB_FIXED_PRIO0_EN
      // Priority grants to requester 0 leave the rotation pointer untouched.
      if (grant_valid && (win != '0)) begin
        last <= win;
      end
`else
      if (grant_valid) begin
        last <= win;
      end
`endif
    end
  end

  assign o_rom_addr = grant_valid ? addr_q[win] : '0;
  assign o_busy     = pending | inflight;
  assign o_rvalid   = inflight;
  assign o_rdata    = (|inflight) ? i_rom_data : '0;

endmodule
